stage_ex_pipe: RTL and testbench
================================

STAGE_EX_PIPE -- requirements
Module: stage_ex_pipe

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 16: datapath width in bits (8..32).
REQ-002 SHALL have parameter IMM_BITS, default 8: immediate field width, taken from instruction[IMM_BITS-1:0].
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  ID/EX holds a valid instruction.
REQ-006 SHALL have port in_ready  output  1  the stage accepts the ID/EX contents this cycle.
REQ-007 SHALL have ports PC, A, B, instruction  input  WORD_SIZE each  ID/EX operands.
REQ-008 SHALL have ports fwdA, fwdB  input  2 each  operand source: 00 ID/EX, 01 ex_aluOut, 10 wb_data, 11 reserved (treated as 00).
REQ-009 SHALL have port wb_data  input  WORD_SIZE  MEM/WB forwarded value.
REQ-010 SHALL have ports aluSrcA, aluSrcB, immSext  input  1 each  A: 0=PC, 1=forwarded A; B: 0=forwarded B, 1=immediate; immediate: 1=sign-extend, 0=zero-extend.
REQ-011 SHALL have port func  input  6  ALU operation.
REQ-012 SHALL have port dest_in  input  2  destination register index.
REQ-013 SHALL have ports flush, stall  input  1 each  kill EX/MEM contents; downstream hold.
REQ-014 SHALL have outputs ex_valid (1), ex_aluOut (WORD_SIZE), ex_storeData (WORD_SIZE), ex_dest (2)  registered EX/MEM contents.

Function
REQ-015 SHALL decode func: 0 ADD, 1 SUB, 2 AND, 3 ORR, 4 NOT A, 5 TCP (two's complement of A), 6 SHL by 1, 7 SHR arithmetic by 1, 8 LHI (B << IMM_BITS), 9 MUL; any other value gives result 0.
REQ-016 SHALL perform arithmetic modulo 2^WORD_SIZE; carry and overflow are discarded.
REQ-017 SHALL set ex_storeData to the forwarded B regardless of aluSrcB.
REQ-018 SHALL run a two-state FSM: IDLE and MUL.
REQ-019 In IDLE with in_valid=1, stall=0, and a non-MUL op, SHALL load the EX/MEM register the next edge (latency 1) and set in_ready=1.
REQ-020 With stall=1, SHALL hold all EX/MEM outputs and set in_ready=0.
REQ-021 With in_valid=0 and stall=0, SHALL clear ex_valid on the next edge.
REQ-022 flush=1 SHALL clear ex_valid on the next edge. Flush overrides stall and aborts MUL, returning the FSM to IDLE.
REQ-023 Forwarding select values SHALL be sampled only in the cycle the operands are captured.

Reset
REQ-024 While reset_n=0, the stage SHALL set ex_valid=0, ex_aluOut=0, ex_storeData=0, ex_dest=0 and FSM=IDLE.
REQ-025 Asserting reset_n low mid-MUL SHALL discard the partial product. in_ready SHALL be 1 when reset is released.

Configuration
REQ-026 With macro STAGE_EX_MUL_EN defined, MUL SHALL be a shift-add operation. In the MUL state:
- in_ready=0.
- Exactly WORD_SIZE cycles elapse after capture.
- The result is the low WORD_SIZE bits of the product, loaded with ex_valid=1 on the edge that leaves MUL.
- If stall=1 at completion, the stage SHALL remain in MUL holding the result until stall=0.
REQ-027 Without STAGE_EX_MUL_EN, MUL SHALL be single-cycle with result 0. The MUL state and its counter SHALL not be synthesised.

Verification
REQ-028 Bench SHALL drive ADD A=0x0005, B=0xFFFF, fwdA=fwdB=00 and check ex_aluOut=0x0004 with ex_valid=1 one cycle later.
REQ-029 Bench SHALL set ex_aluOut=0x1234, fwdA=01, SUB with B=0x0234, and check the result=0x1000.
REQ-030 Bench SHALL drive instruction[7:0]=0x80, aluSrcB=1, ADD A=0, and check 0xFF80 with immSext=1 and 0x0080 with immSext=0.
REQ-031 Bench SHALL hold stall=1 for 3 cycles after a valid ADD and check the outputs stay unchanged and in_ready=0. Bench SHALL then assert flush with stall=1 and check ex_valid=0 on the next edge.
REQ-032 With STAGE_EX_MUL_EN, bench SHALL issue MUL 0x0003*0x0007 and check in_ready=0 for 16 cycles, then ex_aluOut=0x0015. Without the macro, bench SHALL check 0x0000 after 1 cycle.
REQ-033 Bench SHALL assert reset_n=0 at cycle 5 of a MUL and check all outputs are 0 immediately (asynchronously). After release, bench SHALL check in_ready=1.

Source files
------------

// File: rtl/stage_ex_pipe.sv
`default_nettype none
// ============================================================================
// Module   : stage_ex_pipe
// Brief    : EX pipeline stage (forwarding, ALU, EX/MEM register). Defining
//            STAGE_EX_MUL_EN enables a WORD_SIZE-cycle shift-add multiplier.
// Revision : 1.0 - initial release
// ============================================================================
module stage_ex_pipe #(
    parameter int WORD_SIZE = 16,
    parameter int IMM_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WORD_SIZE-1:0] PC,
    input  logic [WORD_SIZE-1:0] A,
    input  logic [WORD_SIZE-1:0] B,
    input  logic [WORD_SIZE-1:0] instruction,
    input  logic [1:0]           fwdA,
    input  logic [1:0]           fwdB,
    input  logic [WORD_SIZE-1:0] wb_data,
    input  logic                 aluSrcA,
    input  logic                 aluSrcB,
    input  logic                 immSext,
    input  logic [5:0]           func,
    input  logic [1:0]           dest_in,
    input  logic                 flush,
    input  logic                 stall,
    output logic                 ex_valid,
    output logic [WORD_SIZE-1:0] ex_aluOut,
    output logic [WORD_SIZE-1:0] ex_storeData,
    output logic [1:0]           ex_dest
);
    localparam logic [5:0] C_OP_ADD = 6'd0;
    localparam logic [5:0] C_OP_SUB = 6'd1;
    localparam logic [5:0] C_OP_AND = 6'd2;
    localparam logic [5:0] C_OP_ORR = 6'd3;
    localparam logic [5:0] C_OP_NOT = 6'd4;
    localparam logic [5:0] C_OP_TCP = 6'd5;
    localparam logic [5:0] C_OP_SHL = 6'd6;
    localparam logic [5:0] C_OP_SHR = 6'd7;
    localparam logic [5:0] C_OP_LHI = 6'd8;
    localparam logic [5:0] C_OP_MUL = 6'd9;

    logic [WORD_SIZE-1:0] w_fwd_a;
    logic [WORD_SIZE-1:0] w_fwd_b;
    logic [WORD_SIZE-1:0] w_imm;
    logic [WORD_SIZE-1:0] w_opa;
    logic [WORD_SIZE-1:0] w_opb;
    logic [WORD_SIZE-1:0] w_alu;
    logic [IMM_BITS-1:0]  w_imm_raw;
    logic                 w_unused_instr;

    assign w_imm_raw      = instruction[IMM_BITS-1:0];
    assign w_unused_instr = ^instruction[WORD_SIZE-1:IMM_BITS];

    // Selector 2'b11 is reserved and falls back to the ID/EX operand.
    always_comb begin
        case (fwdA)
            2'b01:   w_fwd_a = ex_aluOut;
            2'b10:   w_fwd_a = wb_data;
            default: w_fwd_a = A;
        endcase
        case (fwdB)
            2'b01:   w_fwd_b = ex_aluOut;
            2'b10:   w_fwd_b = wb_data;
            default: w_fwd_b = B;
        endcase
    end

    assign w_imm = immSext ? {{(WORD_SIZE-IMM_BITS){w_imm_raw[IMM_BITS-1]}}, w_imm_raw}
                           : {{(WORD_SIZE-IMM_BITS){1'b0}}, w_imm_raw};
    assign w_opa = aluSrcA ? w_fwd_a : PC;
    assign w_opb = aluSrcB ? w_imm : w_fwd_b;

    always_comb begin
        case (func)
            C_OP_ADD: w_alu = w_opa + w_opb;
            C_OP_SUB: w_alu = w_opa - w_opb;
            C_OP_AND: w_alu = w_opa & w_opb;
            C_OP_ORR: w_alu = w_opa | w_opb;
            C_OP_NOT: w_alu = ~w_opa;
            C_OP_TCP: w_alu = -w_opa;
            C_OP_SHL: w_alu = w_opa << 1;
            C_OP_SHR: w_alu = $signed(w_opa) >>> 1;
            C_OP_LHI: w_alu = w_opb << IMM_BITS;
            C_OP_MUL: w_alu = '0;
            default:  w_alu = '0;
        endcase
    end

`ifdef STAGE_EX_MUL_EN
    localparam int CNT_W = $clog2(WORD_SIZE + 1);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(WORD_SIZE - 1);
    localparam logic [CNT_W-1:0] C_CNT_DONE = CNT_W'(WORD_SIZE);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [WORD_SIZE-1:0] r_acc;
    logic [WORD_SIZE-1:0] r_mcand;
    logic [WORD_SIZE-1:0] r_mplier;
    logic [WORD_SIZE-1:0] w_acc_next;
    logic                 w_is_mul;

    assign w_is_mul   = (func == C_OP_MUL);
    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign in_ready   = (r_state == S_IDLE) & ~stall & ~flush;
`else
    assign in_ready   = ~stall & ~flush;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_valid     <= 1'b0;
            ex_aluOut    <= '0;
            ex_storeData <= '0;
            ex_dest      <= 2'b00;
`ifdef STAGE_EX_MUL_EN
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_acc        <= '0;
            r_mcand      <= '0;
            r_mplier     <= '0;
`endif
        end else if (flush) begin
            ex_valid <= 1'b0;
`ifdef STAGE_EX_MUL_EN
            r_state  <= S_IDLE;
        end else if (r_state == S_MUL) begin
            // The last step retires directly so exactly WORD_SIZE edges elapse;
            // a stalled completion parks the product in r_acc at C_CNT_DONE.
            if (r_cnt == C_CNT_DONE) begin
                if (!stall) begin
                    ex_valid  <= 1'b1;
                    ex_aluOut <= r_acc;
                    r_state   <= S_IDLE;
                end
            end else begin
                r_acc    <= w_acc_next;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + 1'b1;
                if ((r_cnt == C_CNT_LAST) && !stall) begin
                    ex_valid  <= 1'b1;
                    ex_aluOut <= w_acc_next;
                    r_state   <= S_IDLE;
                end
            end
`endif
        end else if (!stall) begin
            if (!in_valid) begin
                ex_valid <= 1'b0;
`ifdef STAGE_EX_MUL_EN
            end else if (w_is_mul) begin
                ex_valid     <= 1'b0;
                ex_storeData <= w_fwd_b;
                ex_dest      <= dest_in;
                r_acc        <= '0;
                r_mcand      <= w_opa;
                r_mplier     <= w_opb;
                r_cnt        <= '0;
                r_state      <= S_MUL;
`endif
            end else begin
                ex_valid     <= 1'b1;
                ex_aluOut    <= w_alu;
                ex_storeData <= w_fwd_b;
                ex_dest      <= dest_in;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stage_ex_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_stage_ex_pipe
// Brief    : Self-checking bench for stage_ex_pipe against a cycle-count model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stage_ex_pipe;
    localparam int W  = 16;
    localparam int IB = 8;
`ifdef STAGE_EX_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] PC, A, B, instruction, wb_data;
    logic [1:0]   fwdA, fwdB;
    logic         aluSrcA, aluSrcB, immSext;
    logic [5:0]   func;
    logic [1:0]   dest_in;
    logic         flush, stall;
    logic         ex_valid;
    logic [W-1:0] ex_aluOut, ex_storeData;
    logic [1:0]   ex_dest;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: EX/MEM contents plus cycles left on a pending multiply.
    logic         m_valid;
    logic [W-1:0] m_out, m_store, m_mres;
    logic [1:0]   m_dest;
    int           m_left;

    always #5 clk = ~clk;

    stage_ex_pipe #(.WORD_SIZE(W), .IMM_BITS(IB)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .PC(PC), .A(A), .B(B), .instruction(instruction),
        .fwdA(fwdA), .fwdB(fwdB), .wb_data(wb_data),
        .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .immSext(immSext),
        .func(func), .dest_in(dest_in), .flush(flush), .stall(stall),
        .ex_valid(ex_valid), .ex_aluOut(ex_aluOut),
        .ex_storeData(ex_storeData), .ex_dest(ex_dest)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] ref_alu(input logic [5:0] f, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        case (f)
            6'd0:    return W'(a + b);
            6'd1:    return W'(a - b);
            6'd2:    return a & b;
            6'd3:    return a | b;
            6'd4:    return W'(16'hFFFF - a);
            6'd5:    return W'(32'h10000 - a);
            6'd6:    return W'(a * 2);
            6'd7:    return W'((a / 2) + (a >= 16'h8000 ? 16'h8000 : 16'h0000));
            6'd8:    return W'(b * (1 << IB));
            default: return '0;
        endcase
    endfunction

    task automatic model_reset();
        m_valid = 1'b0; m_out = '0; m_store = '0; m_dest = 2'b00; m_mres = '0; m_left = 0;
    endtask

    task automatic check_outputs(input string pfx);
        check({pfx, ".ex_valid"},     ex_valid,     m_valid);
        check({pfx, ".ex_aluOut"},    ex_aluOut,    m_out);
        check({pfx, ".ex_storeData"}, ex_storeData, m_store);
        check({pfx, ".ex_dest"},      ex_dest,      m_dest);
    endtask

    // One clock: check in_ready, advance the model, then compare after the edge.
    task automatic step(input string pfx);
        logic [W-1:0] fa, fb, opa, opb, imm;
        #1;
        check({pfx, ".in_ready"}, in_ready, (m_left == 0) && !stall && !flush);
        fa  = (fwdA == 2'b01) ? m_out : (fwdA == 2'b10) ? wb_data : A;
        fb  = (fwdB == 2'b01) ? m_out : (fwdB == 2'b10) ? wb_data : B;
        imm = W'(instruction % (1 << IB));
        if (immSext && imm >= W'(1 << (IB - 1))) imm = W'(imm + 32'h10000 - (1 << IB));
        opa = aluSrcA ? fa : PC;
        opb = aluSrcB ? imm : fb;
        if (flush) begin
            m_valid = 1'b0;
            m_left  = 0;
        end else if (m_left > 1) begin
            m_left--;
        end else if (m_left == 1) begin
            if (!stall) begin
                m_valid = 1'b1; m_out = m_mres; m_left = 0;
            end
        end else if (!stall) begin
            if (!in_valid) begin
                m_valid = 1'b0;
            end else if (MUL_EN && func == 6'd9) begin
                m_valid = 1'b0; m_store = fb; m_dest = dest_in;
                m_mres  = W'(opa * opb);
                m_left  = W;
            end else begin
                m_valid = 1'b1; m_out = ref_alu(func, opa, opb); m_store = fb; m_dest = dest_in;
            end
        end
        @(posedge clk);
        #1;
        check_outputs(pfx);
    endtask

    task automatic set_op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        in_valid = 1'b1; func = f; A = a; B = b; PC = 16'h0100; instruction = '0;
        fwdA = 2'b00; fwdB = 2'b00; aluSrcA = 1'b1; aluSrcB = 1'b0; immSext = 1'b0;
        wb_data = 16'hBEEF; dest_in = 2'd1; stall = 1'b0; flush = 1'b0;
    endtask

    task automatic idle_in();
        in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0;
        set_op(6'd0, '0, '0);
        idle_in();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst.ex_valid", ex_valid, 1'b0);
        check("rst.ex_aluOut", ex_aluOut, 16'h0000);
        check("rst.ex_storeData", ex_storeData, 16'h0000);
        check("rst.ex_dest", ex_dest, 2'b00);
        #2 reset_n = 1'b1;
        #1 check("rst.in_ready", in_ready, 1'b1);
        @(posedge clk); #1;

        set_op(6'd0, 16'h0005, 16'hFFFF);
        step("add");
        check("add.value", ex_aluOut, 16'h0004);
        check("add.valid", ex_valid, 1'b1);

        set_op(6'd0, 16'h1234, 16'h0000);
        step("pre_sub");
        set_op(6'd1, 16'h7777, 16'h0234);
        fwdA = 2'b01;
        step("fwd_sub");
        check("fwd_sub.value", ex_aluOut, 16'h1000);

        set_op(6'd0, 16'h0000, 16'h5555);
        instruction = 16'h0080; aluSrcB = 1'b1; immSext = 1'b1;
        step("imm_sext");
        check("imm_sext.value", ex_aluOut, 16'hFF80);
        immSext = 1'b0;
        step("imm_zext");
        check("imm_zext.value", ex_aluOut, 16'h0080);

        set_op(6'd0, 16'h0011, 16'h0022);
        dest_in = 2'd2;
        step("stall_add");
        set_op(6'd3, 16'hF0F0, 16'h0F0F);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step("stall_hold");
            check("stall.in_ready", in_ready, 1'b0);
            check("stall.aluOut", ex_aluOut, 16'h0033);
            check("stall.valid", ex_valid, 1'b1);
        end
        flush = 1'b1;
        step("flush");
        check("flush.valid", ex_valid, 1'b0);

        set_op(6'd9, 16'h0003, 16'h0007);
        step("mul_issue");
        idle_in();
        if (MUL_EN) begin
            for (int i = 0; i < W; i++) begin
                check("mul.in_ready", in_ready, 1'b0);
                step("mul_busy");
            end
            check("mul.value", ex_aluOut, 16'h0015);
            check("mul.valid", ex_valid, 1'b1);

            set_op(6'd9, 16'h00FF, 16'h0101);
            step("mul2_issue");
            idle_in();
            for (int i = 0; i < W - 1; i++) step("mul2_busy");
            stall = 1'b1;
            for (int i = 0; i < 3; i++) step("mul2_stall");
            stall = 1'b0;
            step("mul2_done");
            check("mul2.value", ex_aluOut, 16'hFFFF);
        end else begin
            check("mul_off.value", ex_aluOut, 16'h0000);
            check("mul_off.valid", ex_valid, 1'b1);
        end

        set_op(6'd0, 16'h4321, 16'h0000);
        step("pre_rst");
        set_op(6'd9, 16'h1234, 16'h0005);
        dest_in = 2'd3;
        step("rmul_issue");
        idle_in();
        for (int i = 0; i < 4; i++) step("rmul_busy");
        #2 reset_n = 1'b0;
        #1;
        check("arst.ex_valid", ex_valid, 1'b0);
        check("arst.ex_aluOut", ex_aluOut, 16'h0000);
        check("arst.ex_storeData", ex_storeData, 16'h0000);
        check("arst.ex_dest", ex_dest, 2'b00);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        #1 check("arst.in_ready", in_ready, 1'b1);
        @(posedge clk); #1;

        for (int i = 0; i < 400; i++) begin
            in_valid    = ($urandom_range(0, 3) != 0);
            stall       = ($urandom_range(0, 4) == 0);
            flush       = ($urandom_range(0, 15) == 0);
            func        = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(10, 63))
                                                      : 6'($urandom_range(0, 9));
            PC          = W'($urandom);
            A           = W'($urandom);
            B           = W'($urandom);
            instruction = W'($urandom);
            wb_data     = W'($urandom);
            fwdA        = 2'($urandom_range(0, 3));
            fwdB        = 2'($urandom_range(0, 3));
            aluSrcA     = 1'($urandom_range(0, 1));
            aluSrcB     = 1'($urandom_range(0, 1));
            immSext     = 1'($urandom_range(0, 1));
            dest_in     = 2'($urandom_range(0, 3));
            step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
